book_update_publisher: RTL and testbench

//  Sits directly downstream of Order_Book. On each book_update pulse (Order_Book orderbook_ready), snapshots all bid/ask levels,

---
 rtl/mdp3_book_pkg.sv | 36 +++
 rtl/book_level_sel.sv | 25 ++
 rtl/book_update_publisher.sv | 202 ++++++++++++++++++++
 tb/tb_book_update_publisher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdp3_book_pkg.sv
// Shared types and record-word builders for the order-book update publisher.
// PUB_SEQNUM_EN (in the top) selects the optional batch trailer.
package mdp3_book_pkg;

    localparam int unsigned LEVEL_W     = 88;
    localparam logic [31:0] TRAILER_TAG = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [63:0] price;
        logic [15:0] qty;
        logic [7:0]  num_orders;
    } level_t;

    typedef enum logic {
        SideBid = 1'b0,
        SideAsk = 1'b1
    } side_e;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StHdr,
        StPrice,
        StTrailer
    } pub_state_e;

    function automatic logic [63:0] mk_hdr_word(input logic [31:0] sec, input side_e side,
                                                input logic [6:0] lvl, input level_t l);
        return {sec, side, lvl, l.num_orders, l.qty};
    endfunction

    function automatic logic [63:0] mk_trailer_word(input logic [31:0] seq);
        return {TRAILER_TAG, seq};
    endfunction

endpackage

// File: rtl/book_level_sel.sv
// Selects one working and one shadow level from flattened images; bids occupy
// entries 0..N/2-1, asks the upper half, so idx encodes side and level together.
module book_level_sel
    import mdp3_book_pkg::*;
#(
    parameter int unsigned N  = 20,
    parameter int unsigned IW = 8
) (
    input  logic [N*LEVEL_W-1:0] work,
    input  logic [N*LEVEL_W-1:0] shadow,
    input  logic [IW-1:0]        idx,
    output level_t               work_lvl,
    output level_t               shadow_lvl
);

    always_comb begin
        work_lvl   = '0;
        shadow_lvl = '0;
        if (32'(idx) < N) begin
            work_lvl   = work[LEVEL_W*32'(idx) +: LEVEL_W];
            shadow_lvl = shadow[LEVEL_W*32'(idx) +: LEVEL_W];
        end
    end

endmodule

// File: rtl/book_update_publisher.sv
// Diffs each book snapshot against the last published image and streams 2-word
// records for changed levels. Define PUB_SEQNUM_EN for a per-batch sequence trailer.
module book_update_publisher
    import mdp3_book_pkg::*;
#(
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned PUB_DEPTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     book_update,
    input  logic [31:0]              security_id,
    input  logic [DEPTH*LEVEL_W-1:0] bid_levels,
    input  logic [DEPTH*LEVEL_W-1:0] ask_levels,
    output logic [63:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [15:0]              coalesce_cnt
);

    localparam int unsigned NE = 2 * PUB_DEPTH;
    localparam int unsigned IW = 8;
    localparam int unsigned VW = NE * LEVEL_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
    localparam logic [IW-1:0] PUB_IDX  = IW'(PUB_DEPTH);

    pub_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] work_q, work_d, shadow_q, shadow_d, pend_q, pend_d;
    logic [31:0]   sec_q, sec_d, pend_sec_q, pend_sec_d;
    logic          pend_vld_q, pend_vld_d;
    logic [15:0]   coal_q, coal_d;
`ifdef PUB_SEQNUM_EN
    logic [31:0]   seq_q, seq_d;
    logic          chg_q, chg_d;
`endif

    logic [VW-1:0] snap;
    level_t        work_lvl, shadow_lvl;
    side_e         cur_side;
    logic [6:0]    cur_lvl;
    logic          scan_done, batch_end;

    // Levels at or above PUB_DEPTH are never captured.
    assign snap = {ask_levels[PUB_DEPTH*LEVEL_W-1:0], bid_levels[PUB_DEPTH*LEVEL_W-1:0]};

    book_level_sel #(
        .N  (NE),
        .IW (IW)
    ) u_sel (
        .work       (work_q),
        .shadow     (shadow_q),
        .idx        (idx_q),
        .work_lvl   (work_lvl),
        .shadow_lvl (shadow_lvl)
    );

    assign cur_side     = (idx_q >= PUB_IDX) ? SideAsk : SideBid;
    assign cur_lvl      = 7'((cur_side == SideAsk) ? idx_q - PUB_IDX : idx_q);
    assign busy         = (state_q != StIdle) || pend_vld_q;
    assign coalesce_cnt = coal_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        work_d     = work_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        sec_d      = sec_q;
        pend_sec_d = pend_sec_q;
        pend_vld_d = pend_vld_q;
        coal_d     = coal_q;
`ifdef PUB_SEQNUM_EN
        seq_d      = seq_q;
        chg_d      = chg_q;
`endif
        out_valid  = 1'b0;
        out_data   = '0;
        scan_done  = 1'b0;
        batch_end  = 1'b0;

        case (state_q)
            StIdle: begin
                if (book_update) begin
                    work_d  = snap;
                    sec_d   = security_id;
                    idx_d   = '0;
                    state_d = StScan;
`ifdef PUB_SEQNUM_EN
                    chg_d   = 1'b0;
`endif
                end
            end
            StScan: begin
                if (work_lvl != shadow_lvl) begin
                    state_d = StHdr;
`ifdef PUB_SEQNUM_EN
                    chg_d   = 1'b1;
`endif
                end else if (idx_q == LAST_IDX) begin
                    scan_done = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StHdr: begin
                out_valid = 1'b1;
                out_data  = mk_hdr_word(sec_q, cur_side, cur_lvl, work_lvl);
                if (out_ready) state_d = StPrice;
            end
            StPrice: begin
                out_valid = 1'b1;
                out_data  = work_lvl.price;
                if (out_ready) begin
                    shadow_d[LEVEL_W*32'(idx_q) +: LEVEL_W] = work_lvl;
                    if (idx_q == LAST_IDX) begin
                        scan_done = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
`ifdef PUB_SEQNUM_EN
            StTrailer: begin
                out_valid = 1'b1;
                out_data  = mk_trailer_word(seq_q);
                if (out_ready) begin
                    seq_d     = seq_q + 32'd1;
                    batch_end = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (scan_done) begin
`ifdef PUB_SEQNUM_EN
            if (chg_d) state_d = StTrailer;
            else       batch_end = 1'b1;
`else
            batch_end = 1'b1;
`endif
        end

        // A snapshot arriving on the batch-end cycle supersedes anything pending.
        if (batch_end) begin
            if (book_update || pend_vld_q) begin
                work_d     = book_update ? snap : pend_q;
                sec_d      = book_update ? security_id : pend_sec_q;
                pend_vld_d = 1'b0;
                idx_d      = '0;
                state_d    = StScan;
`ifdef PUB_SEQNUM_EN
                chg_d      = 1'b0;
`endif
                if (book_update && pend_vld_q && coal_q != 16'hFFFF) coal_d = coal_q + 16'd1;
            end else begin
                state_d = StIdle;
            end
        end else if (book_update && state_q != StIdle) begin
            pend_d     = snap;
            pend_sec_d = security_id;
            pend_vld_d = 1'b1;
            if (pend_vld_q && coal_q != 16'hFFFF) coal_d = coal_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            work_q     <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            sec_q      <= '0;
            pend_sec_q <= '0;
            pend_vld_q <= 1'b0;
            coal_q     <= '0;
`ifdef PUB_SEQNUM_EN
            seq_q      <= '0;
            chg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            work_q     <= work_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            sec_q      <= sec_d;
            pend_sec_q <= pend_sec_d;
            pend_vld_q <= pend_vld_d;
            coal_q     <= coal_d;
`ifdef PUB_SEQNUM_EN
            seq_q      <= seq_d;
            chg_q      <= chg_d;
`endif
        end
    end

endmodule

// File: tb/tb_book_update_publisher.sv
// Scoreboard bench: expected records come from diffing each snapshot against the
// bench's own image of what has been published; a negedge monitor pops and compares.
module tb_book_update_publisher;

    localparam int DEPTH     = 10;
    localparam int PUB_DEPTH = 10;
    localparam int NE        = 2 * PUB_DEPTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  book_update = 1'b0;
    logic [31:0]           security_id = '0;
    logic [DEPTH*88-1:0]   bid_levels = '0;
    logic [DEPTH*88-1:0]   ask_levels = '0;
    logic [63:0]           out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic                  busy;
    logic [15:0]           coalesce_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [87:0] pub_img[NE];
    logic [31:0] exp_seq = '0;
    int          exp_coal = 0;
    int          ready_mode = 1;

    always #5 clk = ~clk;

    book_update_publisher #(
        .DEPTH     (DEPTH),
        .PUB_DEPTH (PUB_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .book_update  (book_update),
        .security_id  (security_id),
        .bid_levels   (bid_levels),
        .ask_levels   (ask_levels),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .coalesce_cnt (coalesce_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [87:0] entry(input int i);
        if (i < PUB_DEPTH) return bid_levels[88*i +: 88];
        return ask_levels[88*(i-PUB_DEPTH) +: 88];
    endfunction

    function automatic logic [87:0] mk_level(input logic [63:0] p, input logic [15:0] q,
                                             input logic [7:0] n);
        return {p, q, n};
    endfunction

    // Every level differing from the published image yields header+price, bids first.
    task automatic model_batch();
        bit          any;
        logic [87:0] e;
        logic [6:0]  lv;
        logic        side;
        any = 0;
        for (int i = 0; i < NE; i++) begin
            e = entry(i);
            if (e !== pub_img[i]) begin
                side = (i >= PUB_DEPTH);
                lv   = 7'(side ? i - PUB_DEPTH : i);
                exp_q.push_back({security_id, side, lv, e[7:0], e[23:8]});
                exp_q.push_back(e[87:24]);
                pub_img[i] = e;
                any = 1;
            end
        end
`ifdef PUB_SEQNUM_EN
        if (any) begin
            exp_q.push_back({32'hFFFF_FFFF, exp_seq});
            exp_seq++;
        end
`endif
    endtask

    task automatic issue(input bit model);
        @(posedge clk); #1;
        book_update = 1'b1;
        if (model) model_batch();
        @(posedge clk); #1;
        book_update = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        n_cmp++;
        if (k == 3000) begin
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, k);
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        n_cmp++;
        if (k == 200) begin
            n_bad++;
            $display("FAIL %s: out_valid %b after %0d cycles, expected 1", name, out_valid, k);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NE; i++) pub_img[i] = '0;
        exp_seq  = '0;
        exp_coal = 0;
    endtask

    task automatic set_level(input bit ask, input int lvl, input logic [87:0] v);
        if (ask) ask_levels[88*lvl +: 88] = v;
        else     bid_levels[88*lvl +: 88] = v;
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: handshake is decided by valid&ready seen at the negedge.
    initial begin
        logic        held;
        logic [63:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", {63'b0, out_valid}, 64'd1);
                    chk("stall_data", out_data, held_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected no output", out_data);
                    end else begin
                        chk("record_word", out_data, exp_q.pop_front());
                    end
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
            end
        end
    end

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_coal", {48'b0, coalesce_cnt}, 64'd0);
        reset = 1'b0;

        // 1: single bid level published.
        security_id = 32'd123;
        set_level(0, 0, mk_level(64'hAE, 16'd1, 8'd9));
        issue(1);
        wait_idle("t1_idle");

        // 2: identical snapshot produces nothing.
        issue(1);
        wait_idle("t2_idle");

        // 3: ask3 cleared under backpressure.
        set_level(1, 3, mk_level(64'h1234, 16'd5, 8'd2));
        issue(1);
        wait_idle("t3a_idle");
        set_level(1, 3, '0);
        ready_mode = 0;
        issue(1);
        wait_valid("t3_valid");
        repeat (10) @(posedge clk);
        #1;
        chk("t3_hold_word", out_data, {32'd123, 1'b1, 7'd3, 8'd0, 16'd0});
        ready_mode = 1;
        wait_idle("t3_idle");

        // 4: two snapshots queued behind a stalled batch; the last one wins.
        ready_mode = 0;
        set_level(0, 2, mk_level(64'h55, 16'd7, 8'd1));
        issue(1);
        @(posedge clk);
        security_id = 32'd77;
        set_level(0, 2, mk_level(64'h66, 16'd8, 8'd2));
        issue(0);
        @(posedge clk);
        set_level(0, 4, mk_level(64'h99, 16'd3, 8'd4));
        set_level(1, 1, mk_level(64'h42, 16'd6, 8'd5));
        issue(1);
        exp_coal++;
        chk("t4_coal", {48'b0, coalesce_cnt}, 64'(exp_coal));
        chk("t4_busy", {63'b0, busy}, 64'd1);
        ready_mode = 1;
        wait_idle("t4_idle");

        // 5: bid0 and the last ask level change; then another changed batch.
        set_level(0, 0, mk_level(64'hDEAD_BEEF_0000_0001, 16'hFFFF, 8'hFF));
        set_level(1, 9, mk_level(64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 8'd3));
        issue(1);
        wait_idle("t5a_idle");
        set_level(0, 5, mk_level(64'h5, 16'd5, 8'd5));
        issue(1);
        wait_idle("t5b_idle");

        // 6: reset while the price word is presented.
        ready_mode = 0;
        set_level(0, 6, mk_level(64'h66, 16'd6, 8'd6));
        issue(1);
        wait_valid("t6_valid");
        ready_mode = 1;
        @(posedge clk); #1;
        ready_mode = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", {63'b0, out_valid}, 64'd0);
        chk("t6_async_busy", {63'b0, busy}, 64'd0);
        chk("t6_async_coal", {48'b0, coalesce_cnt}, 64'd0);
        clear_model();
        @(posedge clk); #1;
        reset = 1'b0;
        ready_mode = 2;
        issue(1);
        wait_idle("t6_idle");

        // Random phase: small mutations, occasional no-ops and instrument changes.
        for (int it = 0; it < 40; it++) begin
            int nmut;
            nmut = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) security_id = $urandom;
            for (int m = 0; m < nmut; m++) begin
                if ($urandom_range(0, 3) == 0)
                    set_level($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), '0);
                else
                    set_level($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                              mk_level({$urandom, $urandom}, 16'($urandom), 8'($urandom)));
            end
            issue(1);
            wait_idle("rand_idle");
        end

        ready_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_coal", {48'b0, coalesce_cnt}, 64'(exp_coal));
        chk("final_valid", {63'b0, out_valid}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
